// File: rtl/booth_mul_sequencer_pkg.sv
// Shared constants for the Booth multiplier sequencer: default sizes, FSM encodings, recode helper.
// No logic of its own; no latency, no backpressure.
// Imported by booth_step and booth_mul_sequencer.
package booth_mul_sequencer_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 6;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ITER = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_ADD  = 2'd1,
        OP_SUB  = 2'd2
    } booth_op_t;

    // Radix-2 Booth recode of the current multiplier bit pair {Q[0], q-1}.
    function automatic booth_op_t booth_recode(input logic q0, input logic qm1);
        case ({q0, qm1})
            2'b01:   return OP_ADD;
            2'b10:   return OP_SUB;
            default: return OP_NONE;
        endcase
    endfunction

endpackage

// File: rtl/booth_mul_sequencer_booth_step.sv
// One Booth iteration: drives the borrowed adder's b/cin and forms the shifted {A,Q,q-1}.
// Purely combinational, zero latency.
// No backpressure; outputs are only meaningful while en is high.
module booth_step
    import booth_mul_sequencer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] m,
    input  logic             qm1,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    output logic [WIDTH-1:0] nxt_a,
    output logic [WIDTH-1:0] nxt_q,
    output logic             nxt_qm1
);

    booth_op_t op;
    logic      sgn;

    always_comb begin
        op      = en ? booth_recode(q[0], qm1) : OP_NONE;
        add_b   = '0;
        add_cin = 1'b0;
        case (op)
            OP_ADD: add_b = m;
            OP_SUB: begin
                add_b   = ~m;
                add_cin = 1'b1;
            end
            default: ;
        endcase
        // Sign of the W+1-bit sum, so A - (-2**(W-1)) does not flip sign on overflow.
        sgn = a[WIDTH-1] ^ add_b[WIDTH-1] ^ add_cout;
        {nxt_a, nxt_q, nxt_qm1} = {sgn, add_sum, q};
    end

endmodule

// File: rtl/booth_mul_sequencer.sv
// Radix-2 Booth signed WIDTHxWIDTH multiplier sequencer using an external shared adder.
// Latency: done pulses the cycle after edge E0+WIDTH (E0 = accepting edge); back in IDLE one edge later.
// Backpressure: start is sampled only in IDLE; requests while busy are dropped, never queued.
module booth_mul_sequencer
    import booth_mul_sequencer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout
);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] m_reg;
    logic             qm1_reg;

    logic [WIDTH-1:0] nxt_a;
    logic [WIDTH-1:0] nxt_q;
    logic             nxt_qm1;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .en       (state == ST_ITER),
        .a        (a_reg),
        .q        (q_reg),
        .m        (m_reg),
        .qm1      (qm1_reg),
        .add_sum  (add_sum),
        .add_cout (add_cout),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .nxt_a    (nxt_a),
        .nxt_q    (nxt_q),
        .nxt_qm1  (nxt_qm1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            a_reg   <= '0;
            q_reg   <= '0;
            m_reg   <= '0;
            qm1_reg <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_reg   <= '0;
                        q_reg   <= multiplier;
                        m_reg   <= multiplicand;
                        qm1_reg <= 1'b0;
                        cnt     <= '0;
                        state   <= ST_ITER;
                    end
                end
                ST_ITER: begin
                    a_reg   <= nxt_a;
                    q_reg   <= nxt_q;
                    qm1_reg <= nxt_qm1;
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy  = (state == ST_ITER) || (state == ST_DONE);
    assign done  = (state == ST_DONE);
    assign hi    = a_reg;
    assign lo    = q_reg;
    assign add_a = a_reg;

endmodule

// File: tb/tb_booth_mul_sequencer.sv
// Bench for booth_mul_sequencer: directed corner products, protocol corners and random signed pairs.
// The shared adder is modelled behaviourally; expected products come from plain signed arithmetic.
module tb_booth_mul_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_cin;
    logic [31:0] add_sum;
    logic        add_cout;

    int nchk  = 0;
    int nfail = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

    booth_mul_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .hi           (hi),
        .lo           (lo),
        .add_a        (add_a),
        .add_b        (add_b),
        .add_cin      (add_cin),
        .add_sum      (add_sum),
        .add_cout     (add_cout)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        if (obs !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx;
        logic signed [63:0] sy;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        return sx * sy;
    endfunction

    // Starts one op from IDLE (caller sits #1 after a rising edge), scrambles the operand
    // inputs after acceptance, and returns the result plus the edge count to done.
    task automatic run_op(input logic [31:0] mc, input logic [31:0] mp,
                          output logic [63:0] prod, output int lat);
        multiplicand = mc;
        multiplier   = mp;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start        = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        prod = {hi, lo};
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string tag, input logic [31:0] mc, input logic [31:0] mp,
                            input logic [63:0] exp);
        logic [63:0] prod;
        int          lat;
        run_op(mc, mp, prod, lat);
        chk({tag, "_prod"}, prod, exp);
        chk({tag, "_lat"}, 64'(lat), 64'd32);
        chk({tag, "_idle"}, {62'd0, busy, done}, 64'd0);
        chk({tag, "_hold"}, {hi, lo}, exp);
    endtask

    initial begin
        logic [63:0] prod;
        logic [63:0] exp;
        logic [31:0] x;
        logic [31:0] y;
        int          lat;
        int          pulses;
        int          t_done [3];
        int          n;

        rst_n        = 1'b0;
        start        = 1'b0;
        multiplicand = 32'h1234_5678;
        multiplier   = 32'h9abc_def0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", {hi, lo}, 64'd0);
        chk("rst_flags", {61'd0, busy, done, add_cin}, 64'd0);
        chk("rst_addb", 64'(add_b), 64'd0);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        directed("m3x5",   32'd3,          32'd5,          64'h0000_0000_0000_000F);
        directed("mn7x6",  32'hFFFF_FFF9,  32'd6,          64'hFFFF_FFFF_FFFF_FFD6);
        directed("mn1xn1", 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'h0000_0000_0000_0001);
        directed("mminsq", 32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000);
        directed("mmaxmin",32'h7FFF_FFFF,  32'h8000_0000,  64'hC000_0000_8000_0000);

        // Second start at iteration 10 must be dropped.
        multiplicand = 32'd1234;
        multiplier   = 32'hFFFF_FF00;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        multiplicand = 32'd77;
        multiplier   = 32'd99;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        pulses = 0;
        prod   = '0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                pulses++;
                prod = {hi, lo};
            end
            @(posedge clk);
            #1;
        end
        chk("busy_start_pulses", 64'(pulses), 64'd1);
        chk("busy_start_prod", prod, ref_prod(32'd1234, 32'hFFFF_FF00));
        chk("busy_start_idle", 64'(busy), 64'd0);

        // Asynchronous abort at iteration 17.
        multiplicand = 32'hDEAD_BEEF;
        multiplier   = 32'h0BAD_F00D;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        chk("abort_flags", {62'd0, busy, done}, 64'd0);
        chk("abort_outs", {hi, lo}, 64'd0);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_nodone", 64'(done), 64'd0);
        directed("post_rst", 32'd2, 32'd3, 64'd6);

        // start held high: three back-to-back ops.
        multiplicand = 32'hFFFF_FFFD;
        multiplier   = 32'd1000;
        start        = 1'b1;
        n            = 0;
        for (int i = 0; i < 150 && n < 3; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                t_done[n] = cyc;
                chk("held_prod", {hi, lo}, ref_prod(32'hFFFF_FFFD, 32'd1000));
                n++;
            end
        end
        start = 1'b0;
        chk("held_count", 64'(n), 64'd3);
        if (n == 3) begin
            chk("held_gap1", 64'(t_done[1] - t_done[0]), 64'd34);
            chk("held_gap2", 64'(t_done[2] - t_done[1]), 64'd34);
        end
        @(posedge clk);
        #1;
        chk("held_idle", 64'(busy), 64'd0);

        for (int i = 0; i < 1000; i++) begin
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: x = 32'h8000_0000;
                1: y = 32'h7FFF_FFFF;
                2: y = 32'hFFFF_FFFF;
                default: ;
            endcase
            exp = ref_prod(x, y);
            run_op(x, y, prod, lat);
            chk("rand_prod", prod, exp);
            if (lat != 32) chk("rand_lat", 64'(lat), 64'd32);
        end

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
